knight_scanner: RTL



---
 rtl/knight_scanner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/knight_scanner.sv
// rtl/knight_scanner.sv - WIDTH-LED knight scanner with prescaled bounce/rotate/hold stepping
// Optional comet tail enabled by defining KNIGHT_SCANNER_TRAIL_EN (adds parameter TRAIL).
module knight_scanner #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16,
`ifdef KNIGHT_SCANNER_TRAIL_EN
    parameter int TRAIL = 2,
`endif
    localparam int PW = $clog2(WIDTH)
) (
    input  logic             ck,
    input  logic             res,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             up,
    output logic [PW-1:0]    pos,
    output logic             step
);

    typedef enum logic [1:0] {
        M_BOUNCE = 2'b00,
        M_UP     = 2'b01,
        M_DOWN   = 2'b10,
        M_HOLD   = 2'b11
    } mode_e;

    localparam logic [PW-1:0] POS_TOP = PW'(WIDTH - 1);
    localparam logic [PW-1:0] POS_ONE = PW'(1);

    logic [DIV_W-1:0] count, count_nxt;
    logic [PW-1:0]    pos_nxt;
    logic             up_nxt;
    logic             adv, fire;
    logic [WIDTH-1:0] out_nxt;

    function automatic logic [WIDTH-1:0] dec(input logic [PW-1:0] p);
        dec = {{(WIDTH-1){1'b0}}, 1'b1} << p;
    endfunction

    always_comb begin
        adv       = en && (mode_e'(mode) != M_HOLD);
        // Compare against the live div so a shrinking divisor fires immediately.
        fire      = adv && (count >= div);
        count_nxt = count;
        pos_nxt   = pos;
        up_nxt    = up;
        if (adv) begin
            count_nxt = fire ? '0 : count + {{(DIV_W-1){1'b0}}, 1'b1};
        end
        if (fire) begin
            case (mode_e'(mode))
                M_BOUNCE: begin
                    if (up) begin
                        if (pos == POS_TOP) begin
                            pos_nxt = POS_TOP - POS_ONE;
                            up_nxt  = 1'b0;
                        end else begin
                            pos_nxt = pos + POS_ONE;
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_nxt = POS_ONE;
                            up_nxt  = 1'b1;
                        end else begin
                            pos_nxt = pos - POS_ONE;
                        end
                    end
                end
                M_UP: begin
                    pos_nxt = (pos == POS_TOP) ? '0 : pos + POS_ONE;
                    up_nxt  = 1'b1;
                end
                M_DOWN: begin
                    pos_nxt = (pos == '0) ? POS_TOP : pos - POS_ONE;
                    up_nxt  = 1'b0;
                end
                default: begin
                    pos_nxt = pos;
                end
            endcase
        end
    end

`ifdef KNIGHT_SCANNER_TRAIL_EN
    localparam int TD = (TRAIL > 0) ? TRAIL : 1;

    logic [PW-1:0] hist_pos     [TD];
    logic [PW-1:0] hist_pos_nxt [TD];
    logic [TD-1:0] hist_vld, hist_vld_nxt;

    // History shifts only on steps; entry 0 is the most recent previous head.
    always_comb begin
        hist_pos_nxt = hist_pos;
        hist_vld_nxt = hist_vld;
        if (fire && (TRAIL > 0)) begin
            hist_pos_nxt[0] = pos;
            hist_vld_nxt[0] = 1'b1;
            for (int i = 1; i < TD; i++) begin
                hist_pos_nxt[i] = hist_pos[i-1];
                hist_vld_nxt[i] = hist_vld[i-1];
            end
        end
        out_nxt = dec(pos_nxt);
        for (int i = 0; i < TD; i++) begin
            if (hist_vld_nxt[i]) begin
                out_nxt = out_nxt | dec(hist_pos_nxt[i]);
            end
        end
    end

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            hist_pos <= '{default: '0};
            hist_vld <= '0;
        end else begin
            hist_pos <= hist_pos_nxt;
            hist_vld <= hist_vld_nxt;
        end
    end
`else
    always_comb begin
        out_nxt = dec(pos_nxt);
    end
`endif

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            count <= '0;
            pos   <= '0;
            up    <= 1'b1;
            step  <= 1'b0;
            out   <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count <= count_nxt;
            pos   <= pos_nxt;
            up    <= up_nxt;
            step  <= fire;
            out   <= out_nxt;
        end
    end

endmodule
